cmplx_mult_seq: RTL and testbench

CMPLX_MULT_SEQ -- requirements
Module: cmplx_mult_seq

---
 rtl/cmplx_mult_seq_pkg.sv | 53 +++++
 rtl/vedic_12x12.sv | 38 +++
 rtl/cmplx_mult_seq.sv | 193 +++++++++++++++++++
 tb/tb_cmplx_mult_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmplx_mult_seq_pkg.sv
// Shared types, widths and helpers for the sequential complex multiplier.
package cmplx_mult_seq_pkg;

    localparam int XW = 12;
    localparam int PW = 24;
    localparam int AW = 26;

    localparam int SAT_MAX = 2047;
    localparam int SAT_MIN = -2048;
    localparam logic signed [AW-1:0] ACC_SAT_MAX = 26'sd2047;
    localparam logic signed [AW-1:0] ACC_SAT_MIN = -26'sd2048;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // Product issue order through the shared multiplier
    localparam int         N_PROD = 4;
    localparam logic [1:0] P_RR   = 2'd0;
    localparam logic [1:0] P_II   = 2'd1;
    localparam logic [1:0] P_RI   = 2'd2;
    localparam logic [1:0] P_IR   = 2'd3;

    typedef struct packed {
        logic                  clip;
        logic signed [XW-1:0]  val;
    } sat_t;

    // Unsigned magnitude; -2048 maps to 2048 (12'h800)
    function automatic logic [XW-1:0] mag(input logic signed [XW-1:0] v);
        logic [XW-1:0] u;
        u = v;
        return v[XW-1] ? (~u + 1'b1) : u;
    endfunction

    function automatic sat_t saturate(input logic signed [AW-1:0] v);
        sat_t s;
        s.clip = 1'b0;
        s.val  = v[XW-1:0];
        if (v > ACC_SAT_MAX) begin
            s.clip = 1'b1;
            s.val  = XW'(SAT_MAX);
        end else if (v < ACC_SAT_MIN) begin
            s.clip = 1'b1;
            s.val  = XW'(SAT_MIN);
        end
        return s;
    endfunction

endpackage

// File: rtl/vedic_12x12.sv
// 12x12 unsigned multiplier built from four 6x6 partial products, registered over LAT stages.
module vedic_12x12
    import cmplx_mult_seq_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic [XW-1:0] a,
    input  logic [XW-1:0] b,
    output logic [PW-1:0] c
);

    logic [5:0]    al, ah, bl, bh;
    logic [11:0]   ll, lh, hl, hh;
    logic [12:0]   mid;
    logic [PW-1:0] prod;
    logic [PW-1:0] pipe_q [LAT];

    assign {ah, al} = a;
    assign {bh, bl} = b;
    assign ll   = al * bl;
    assign lh   = al * bh;
    assign hl   = ah * bl;
    assign hh   = ah * bh;
    assign mid  = 13'(lh) + 13'(hl);
    assign prod = {hh, ll} + {5'b0, mid, 6'b0};

    // Datapath only; validity is tracked by the caller's tag pipeline
    always_ff @(posedge clk) begin
        pipe_q[0] <= prod;
        for (int i = 1; i < LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign c = pipe_q[LAT-1];

endmodule

// File: rtl/cmplx_mult_seq.sv
// Sequential complex multiply (sample x Q1.11 twiddle) through one shared 12x12 multiplier.
//   state   | meaning
//   S_IDLE  | ready for a new sample/twiddle pair
//   S_ISSUE | one magnitude product per cycle into the multiplier
//   S_DRAIN | waiting for the last product, then round/saturate
//   S_HOLD  | result presented until out_ready
module cmplx_mult_seq
    import cmplx_mult_seq_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int FRAC    = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [XW-1:0] xr,
    input  logic signed [XW-1:0] xi,
    input  logic signed [XW-1:0] wr,
    input  logic signed [XW-1:0] wi,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [XW-1:0] yr,
    output logic signed [XW-1:0] yi,
    output logic                 sat
);

    localparam int CW = $clog2(MUL_LAT + 5);
    localparam logic signed [AW-1:0] RND_HALF = AW'(2 ** (FRAC - 1));

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [XW-1:0]        mxr_q, mxi_q, mwr_q, mwi_q;
    logic                 sxr_q, sxi_q, swr_q, swi_q;
    logic [2:0]           tag_q [MUL_LAT];
    logic signed [AW-1:0] acc_r_q, acc_i_q;
    logic signed [XW-1:0] yr_q, yi_q;
    logic                 sat_q;

    logic                 accept;
    logic [1:0]           issue_idx;
    logic [XW-1:0]        mul_a, mul_b;
    logic [PW-1:0]        mul_c;
    logic [2:0]           ret_tag;
    logic                 ret_sgn;
    logic [PW:0]          ret_mag;
    logic signed [PW:0]   prod_s;
    logic signed [AW-1:0] prod_ext;
    logic signed [AW-1:0] sum_r, sum_i, shr_r, shr_i;
    sat_t                 sr, si;
    logic                 finish;

    assign accept    = in_valid && (state_q == S_IDLE);
    assign issue_idx = 2'd3 - cnt_q[1:0];
    assign finish    = (state_q == S_DRAIN) && (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ISSUE;
                    cnt_d   = CW'(N_PROD - 1);
                end
            end
            S_ISSUE: begin
                if (cnt_q == '0) begin
                    state_d = S_DRAIN;
                    cnt_d   = CW'(MUL_LAT + 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) state_d = S_HOLD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_HOLD: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {mxr_q, mxi_q, mwr_q, mwi_q} <= '0;
            {sxr_q, sxi_q, swr_q, swi_q} <= '0;
        end else if (accept) begin
            mxr_q <= mag(xr);
            mxi_q <= mag(xi);
            mwr_q <= mag(wr);
            mwi_q <= mag(wi);
            {sxr_q, sxi_q, swr_q, swi_q} <= {xr[XW-1], xi[XW-1], wr[XW-1], wi[XW-1]};
        end
    end

    always_comb begin
        mul_a = mxr_q;
        mul_b = mwr_q;
        case (issue_idx)
            P_II:    begin mul_a = mxi_q; mul_b = mwi_q; end
            P_RI:    begin mul_a = mxr_q; mul_b = mwi_q; end
            P_IR:    begin mul_a = mxi_q; mul_b = mwr_q; end
            default: begin mul_a = mxr_q; mul_b = mwr_q; end
        endcase
    end

    vedic_12x12 #(.LAT(MUL_LAT)) u_mul (
        .a   (mul_a),
        .b   (mul_b),
        .clk (clk),
        .c   (mul_c)
    );

    // Tag = {valid, product index}; clearing it on reset discards in-flight products
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MUL_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= {state_q == S_ISSUE, issue_idx};
            for (int i = 1; i < MUL_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign ret_tag = tag_q[MUL_LAT-1];

    always_comb begin
        case (ret_tag[1:0])
            P_II:    ret_sgn = sxi_q ^ swi_q;
            P_RI:    ret_sgn = sxr_q ^ swi_q;
            P_IR:    ret_sgn = sxi_q ^ swr_q;
            default: ret_sgn = sxr_q ^ swr_q;
        endcase
    end

    assign ret_mag  = {1'b0, mul_c};
    assign prod_s   = ret_sgn ? -signed'(ret_mag) : signed'(ret_mag);
    assign prod_ext = {prod_s[PW], prod_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r_q <= '0;
            acc_i_q <= '0;
        end else if (accept) begin
            acc_r_q <= '0;
            acc_i_q <= '0;
        end else if (ret_tag[2]) begin
            case (ret_tag[1:0])
                P_RR:    acc_r_q <= acc_r_q + prod_ext;
                P_II:    acc_r_q <= acc_r_q - prod_ext;
                default: acc_i_q <= acc_i_q + prod_ext;
            endcase
        end
    end

    assign sum_r = acc_r_q + RND_HALF;
    assign sum_i = acc_i_q + RND_HALF;
    assign shr_r = sum_r >>> FRAC;
    assign shr_i = sum_i >>> FRAC;
    assign sr    = saturate(shr_r);
    assign si    = saturate(shr_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            yr_q  <= '0;
            yi_q  <= '0;
            sat_q <= 1'b0;
        end else if (finish) begin
            yr_q  <= sr.val;
            yi_q  <= si.val;
            sat_q <= sr.clip | si.clip;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_HOLD);
    assign yr        = yr_q;
    assign yi        = yi_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_cmplx_mult_seq.sv
// Randomised and directed bench for cmplx_mult_seq against an arithmetic reference model.
module tb_cmplx_mult_seq;

    localparam int MUL_LAT = 2;
    localparam int FRAC    = 11;
    localparam int LAT     = MUL_LAT + 6;
    localparam int BOUND   = 40;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic signed [11:0] xr = '0, xi = '0, wr = '0, wi = '0;
    logic               in_ready, out_valid, sat;
    logic signed [11:0] yr, yi;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cmplx_mult_seq #(.MUL_LAT(MUL_LAT), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .xr        (xr),
        .xi        (xi),
        .wr        (wr),
        .wi        (wi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .yr        (yr),
        .yi        (yi),
        .sat       (sat)
    );

    // Complex product scaled by 2^-FRAC, floor-rounded after adding half an LSB, clipped to 12 bits
    function automatic void model(input int a, b, c, d, output int er, output int ei, output bit es);
        longint pr, pi, rr, ri;
        bit cr, ci;
        pr = longint'(a) * c - longint'(b) * d;
        pi = longint'(a) * d + longint'(b) * c;
        rr = (pr + (longint'(1) << (FRAC - 1))) >>> FRAC;
        ri = (pi + (longint'(1) << (FRAC - 1))) >>> FRAC;
        cr = (rr > 2047) || (rr < -2048);
        ci = (ri > 2047) || (ri < -2048);
        er = (rr > 2047) ? 2047 : (rr < -2048) ? -2048 : int'(rr);
        ei = (ri > 2047) ? 2047 : (ri < -2048) ? -2048 : int'(ri);
        es = cr | ci;
    endfunction

    function automatic int rnd12();
        if ($urandom_range(7) == 0) return -2048;
        return int'($urandom_range(4095)) - 2048;
    endfunction

    function automatic int sv(input logic signed [11:0] v);
        return int'(v);
    endfunction

    // Drives one pair, waits (bounded) for the result and completes the handshake
    task automatic do_txn(input int a, b, c, d, output int ryr, output int ryi, output bit rsat,
                          output int lat, output bit post_ok);
        xr = 12'(a); xi = 12'(b); wr = 12'(c); wi = 12'(d);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < BOUND) begin
            @(posedge clk); #1;
            lat++;
        end
        ryr = sv(yr); ryi = sv(yi); rsat = sat;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        post_ok = (out_valid === 1'b0) && (in_ready === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (yr !== 12'sd0 || yi !== 12'sd0) begin failures++; $display("FAIL reset_y got=%0d,%0d exp=0,0", yr, yi); end
        checks++; if (sat !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b exp=0", sat); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int tv [3][4];
        int gr, gi, lat, er, ei;
        bit gs, es, ok;
        tv[0] = '{1024, 0, 2047, 0};
        tv[1] = '{-2048, -2048, -2048, 0};
        tv[2] = '{100, -50, 0, -2048};
        for (int k = 0; k < 3; k++) begin
            model(tv[k][0], tv[k][1], tv[k][2], tv[k][3], er, ei, es);
            do_txn(tv[k][0], tv[k][1], tv[k][2], tv[k][3], gr, gi, gs, lat, ok);
            checks++; if (lat !== LAT) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", k, lat, LAT); end
            checks++; if (gr !== er || gi !== ei) begin failures++; $display("FAIL dir%0d_y got=%0d,%0d exp=%0d,%0d", k, gr, gi, er, ei); end
            checks++; if (gs !== es) begin failures++; $display("FAIL dir%0d_sat got=%b exp=%b", k, gs, es); end
            checks++; if (!ok) begin failures++; $display("FAIL dir%0d_handshake got=ov%b,ir%b exp=ov0,ir1", k, out_valid, in_ready); end
        end
    endtask

    task automatic test_random();
        int a, b, c, d, gr, gi, lat, er, ei;
        bit gs, es, ok;
        for (int k = 0; k < 16; k++) begin
            a = rnd12(); b = rnd12(); c = rnd12(); d = rnd12();
            model(a, b, c, d, er, ei, es);
            do_txn(a, b, c, d, gr, gi, gs, lat, ok);
            checks++; if (lat !== LAT) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", k, lat, LAT); end
            checks++; if (gr !== er || gi !== ei || gs !== es) begin
                failures++;
                $display("FAIL rnd%0d_result x=(%0d,%0d) w=(%0d,%0d) got=%0d,%0d,%b exp=%0d,%0d,%b",
                         k, a, b, c, d, gr, gi, gs, er, ei, es);
            end
            checks++; if (!ok) begin failures++; $display("FAIL rnd%0d_handshake got=ov%b,ir%b exp=ov0,ir1", k, out_valid, in_ready); end
        end
    endtask

    task automatic test_backpressure();
        int a, b, c, d, er, ei, lat, cr, ci;
        bit es, cs;
        a = 1500; b = -900; c = 1234; d = -567;
        model(a, b, c, d, er, ei, es);
        xr = 12'(a); xi = 12'(b); wr = 12'(c); wi = 12'(d);
        in_valid = 1'b1;
        @(posedge clk); #1;
        xr = 12'(rnd12()); xi = 12'(rnd12()); wr = 12'(rnd12()); wi = 12'(rnd12());
        lat = 0;
        while (out_valid !== 1'b1 && lat < BOUND) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== LAT) begin failures++; $display("FAIL bp_latency got=%0d exp=%0d", lat, LAT); end
        cr = sv(yr); ci = sv(yi); cs = sat;
        checks++; if (cr !== er || ci !== ei || cs !== es) begin failures++; $display("FAIL bp_result got=%0d,%0d,%b exp=%0d,%0d,%b", cr, ci, cs, er, ei, es); end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sv(yr) !== er || sv(yi) !== ei || sat !== es) begin
                failures++;
                $display("FAIL bp_hold%0d got=ov%b,ir%b,%0d,%0d,%b exp=ov1,ir0,%0d,%0d,%b",
                         k, out_valid, in_ready, yr, yi, sat, er, ei, es);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=ov%b,ir%b exp=ov0,ir1", out_valid, in_ready); end
        repeat (LAT + 2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_extra got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        int gr, gi, lat, er, ei, a, b, c, d;
        bit gs, es, ok;
        do_txn(1024, 0, 2047, 0, gr, gi, gs, lat, ok);
        xr = 12'(1900); xi = 12'(-1700); wr = 12'(2000); wi = 12'(-1999);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_hs got=ir%b,ov%b exp=ir1,ov0", in_ready, out_valid); end
        checks++; if (yr !== 12'sd0 || yi !== 12'sd0 || sat !== 1'b0) begin failures++; $display("FAIL rstmid_y got=%0d,%0d,%b exp=0,0,0", yr, yi, sat); end
        #2;
        rst = 1'b0;
        a = rnd12(); b = rnd12(); c = 300; d = -800;
        model(a, b, c, d, er, ei, es);
        do_txn(a, b, c, d, gr, gi, gs, lat, ok);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL rstmid_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (gr !== er || gi !== ei || gs !== es) begin failures++; $display("FAIL rstmid_result got=%0d,%0d,%b exp=%0d,%0d,%b", gr, gi, gs, er, ei, es); end
    endtask

    task automatic test_back_to_back();
        int pr [3][4];
        int exp_r [$], exp_i [$];
        bit exp_s [$];
        int nacc, nres, er, ei, gr, gi, qr, qi;
        bit es, gs, qs, acc, ov;
        for (int k = 0; k < 3; k++) pr[k] = '{rnd12(), rnd12(), rnd12(), rnd12()};
        nacc = 0; nres = 0;
        xr = 12'(pr[0][0]); xi = 12'(pr[0][1]); wr = 12'(pr[0][2]); wi = 12'(pr[0][3]);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 4 * BOUND && nres < 3; cyc++) begin
            acc = (in_valid === 1'b1) && (in_ready === 1'b1);
            ov  = (out_valid === 1'b1);
            gr = sv(yr); gi = sv(yi); gs = sat;
            @(posedge clk); #1;
            if (acc) begin
                model(pr[nacc][0], pr[nacc][1], pr[nacc][2], pr[nacc][3], er, ei, es);
                exp_r.push_back(er); exp_i.push_back(ei); exp_s.push_back(es);
                nacc++;
                if (nacc < 3) begin
                    xr = 12'(pr[nacc][0]); xi = 12'(pr[nacc][1]); wr = 12'(pr[nacc][2]); wi = 12'(pr[nacc][3]);
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (ov) begin
                checks++;
                if (exp_r.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_unexpected got=%0d,%0d exp=no result", gr, gi);
                end else begin
                    qr = exp_r.pop_front(); qi = exp_i.pop_front(); qs = exp_s.pop_front();
                    if (gr !== qr || gi !== qi || gs !== qs) begin
                        failures++;
                        $display("FAIL b2b_result%0d got=%0d,%0d,%b exp=%0d,%0d,%b", nres, gr, gi, gs, qr, qi, qs);
                    end
                end
                nres++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (nacc !== 3) begin failures++; $display("FAIL b2b_accepts got=%0d exp=3", nacc); end
        checks++; if (nres !== 3) begin failures++; $display("FAIL b2b_results got=%0d exp=3", nres); end
        repeat (LAT + 2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_no_extra got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
